// File: rtl/packet_injector_pkg.sv
// packet_injector_pkg: shared channel/packet constants and port codes.
// Optional feature macro: PACKET_SERIAL_STAMP_EN (serial stamp in the header).
package packet_injector_pkg;

    // Channel and packet geometry
    localparam int unsigned PKT_CHANNEL_WIDTH = 32;
    localparam int unsigned PKT_FLITS         = 5;
    localparam int unsigned PKT_WIDTH         = PKT_FLITS * PKT_CHANNEL_WIDTH;

    // Serial stamp field inside the header flit
    localparam int unsigned PKT_SERIAL_MSB    = 145;
    localparam int unsigned PKT_SERIAL_LSB    = 128;
    localparam int unsigned PKT_SERIAL_WIDTH  = PKT_SERIAL_MSB - PKT_SERIAL_LSB + 1;

    typedef logic [PKT_WIDTH-1:0]         packet_t;
    typedef logic [PKT_CHANNEL_WIDTH-1:0] flit_t;

    // Router port codes
    localparam logic [2:0] PORT_X_NEG = 3'd0;
    localparam logic [2:0] PORT_X_POS = 3'd1;
    localparam logic [2:0] PORT_Y_NEG = 3'd2;
    localparam logic [2:0] PORT_Y_POS = 3'd3;
    localparam logic [2:0] PORT_PE    = 3'd4;

    // Header flit of a full packet
    function automatic flit_t header_of(input packet_t pkt);
        return pkt[PKT_WIDTH-1 -: PKT_CHANNEL_WIDTH];
    endfunction

endpackage

// File: rtl/packet_injector_credit_counter.sv
// credit_counter: saturating credit counter for credit-based flow control.
// Reloads to CREDITS on reset; flags a credit returned while already full.
module credit_counter
    import packet_injector_pkg::*;
#(
    parameter int unsigned CREDITS = 4,
    localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          consume,
    input  logic          give,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          overflow
);

    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Next count: consume and give together cancel out
    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        if (give && !consume) begin
            if (count_q == CW'(CREDITS)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (consume && !give && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter and overflow pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= CW'(CREDITS);
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign nonzero  = (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/packet_injector.sv
// packet_injector: serializes a 160-bit packet into 32-bit flits on one
// network channel under credit-based flow control. Channel idles at zero.
// Optional feature macro: PACKET_SERIAL_STAMP_EN (18-bit serial in header).
module packet_injector
    import packet_injector_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = PKT_CHANNEL_WIDTH,
    parameter int unsigned FLITS         = PKT_FLITS,
    parameter int unsigned CREDITS       = 4,
    parameter logic [2:0]  PORT          = PORT_X_NEG,
    parameter int unsigned ID            = 0,
    localparam int unsigned PW           = FLITS * CHANNEL_WIDTH,
    localparam int unsigned CCW          = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PW-1:0]            packet_in,
    input  logic                     packet_valid,
    output logic                     packet_ready,
    output logic [CHANNEL_WIDTH-1:0] channel_out,
    input  logic                     credit_in,
    output logic [CCW-1:0]           credit_count,
    output logic                     header_error,
    output logic                     credit_overflow
);

    localparam int unsigned IW = (FLITS > 1) ? $clog2(FLITS) : 1;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SEND = 1'b1;

    // PORT and ID are informational; an out-of-range port code leaves a
    // marker net in the elaborated design.
    if ((PORT > PORT_PE) || (ID == 32'hFFFF_FFFF)) begin : g_cfg_invalid
        logic cfg_invalid_marker;
        assign cfg_invalid_marker = 1'b1;
    end

    logic                     state_q, state_d;
    logic [IW-1:0]            flit_idx_q, flit_idx_d;
    logic [PW-1:0]            shift_q, shift_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic                     header_error_q, header_error_d;

    logic [PW-1:0]            pkt_stamped;
    logic [CHANNEL_WIDTH-1:0] pkt_header;
    logic                     credit_nonzero;
    logic                     accept;
    logic                     hdr_zero;
    logic                     send;

`ifdef PACKET_SERIAL_STAMP_EN
    logic [PKT_SERIAL_WIDTH-1:0] serial_q, serial_d;

    // Overwrite the header serial field with the running packet serial
    always_comb begin
        pkt_stamped = packet_in;
        pkt_stamped[PKT_SERIAL_MSB:PKT_SERIAL_LSB] = serial_q;
    end

    // Serial advances only for packets actually sent; wraps naturally
    always_comb begin
        serial_d = serial_q;
        if (send) begin
            serial_d = serial_q + PKT_SERIAL_WIDTH'(1);
        end
    end

    // Serial counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            serial_q <= '0;
        end else begin
            serial_q <= serial_d;
        end
    end
`else
    assign pkt_stamped = packet_in;
`endif

    assign pkt_header   = pkt_stamped[PW-1 -: CHANNEL_WIDTH];
    assign packet_ready = (state_q == STATE_IDLE) && credit_nonzero;
    assign accept       = packet_valid && packet_ready;
    assign hdr_zero     = (pkt_header == '0);
    assign send         = accept && !hdr_zero;

    credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .consume  (send),
        .give     (credit_in),
        .count    (credit_count),
        .nonzero  (credit_nonzero),
        .overflow (credit_overflow)
    );

    // Serializer FSM. The output flit is registered separately from the
    // shift register, so the shift register holds the flits still to come.
    always_comb begin
        state_d        = state_q;
        flit_idx_d     = flit_idx_q;
        shift_d        = shift_q;
        chan_d         = '0;
        header_error_d = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    if (hdr_zero) begin
                        header_error_d = 1'b1;
                    end else begin
                        state_d    = STATE_SEND;
                        flit_idx_d = '0;
                        chan_d     = pkt_header;
                        shift_d    = pkt_stamped << CHANNEL_WIDTH;
                    end
                end
            end
            STATE_SEND: begin
                if (flit_idx_q == IW'(FLITS - 1)) begin
                    state_d    = STATE_IDLE;
                    flit_idx_d = '0;
                    shift_d    = '0;
                end else begin
                    chan_d     = shift_q[PW-1 -: CHANNEL_WIDTH];
                    shift_d    = shift_q << CHANNEL_WIDTH;
                    flit_idx_d = flit_idx_q + IW'(1);
                end
            end
            default: begin
                state_d    = STATE_IDLE;
                flit_idx_d = '0;
                shift_d    = '0;
            end
        endcase
    end

    // FSM, shift register and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= STATE_IDLE;
            flit_idx_q     <= '0;
            shift_q        <= '0;
            chan_q         <= '0;
            header_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flit_idx_q     <= flit_idx_d;
            shift_q        <= shift_d;
            chan_q         <= chan_d;
            header_error_q <= header_error_d;
        end
    end

    assign channel_out  = chan_q;
    assign header_error = header_error_q;

endmodule

// File: doc/packet_injector.md
# packet_injector

Synthesizable packet transmitter for one on-chip network channel. Accepts a 160-bit packet from a local producer, serializes it into five 32-bit flits on `channel_out`, and enforces credit-based flow control against the downstream input buffer. Sits at the injection side of every router port, or the PE port, and drives the same channel that the `sink` receiver model observes. The channel is idle at all-zeros, and the receiver returns one credit per packet.

## Interface
- `CHANNEL_WIDTH`, 32, flit width; fixed by `packet_type.vh`.
- `FLITS`, 5, flits per packet; packet width = `FLITS*CHANNEL_WIDTH` = 160.
- `CREDITS`, 4, downstream buffer depth in packets; counter reset value.
- `PORT`, `X_NEG`, port code (`system.vh`); informational only.
- `ID`, 0, instance number; informational only.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `packet_in`  in  160  packet to send. Header flit is [159:128] and goes out first; tail flit is [31:0].
- `packet_valid`  in  1  producer has a packet.
- `packet_ready`  out  1  block accepts `packet_in` this cycle.
- `channel_out`  out  32  registered flit output; all-zeros when idle.
- `credit_in`  in  1  one credit returned per cycle sampled high.
- `credit_count`  out  `$clog2(CREDITS+1)`  current credits available.
- `header_error`  out  1  one-cycle pulse: zero-valued header rejected.
- `credit_overflow`  out  1  one-cycle pulse: credit returned while counter full.

## Operation
- **FSM states:** IDLE and SEND. Flit counter `flit_idx` runs 0..FLITS-1.
- **Ready:** `packet_ready` = (state==IDLE) && (`credit_count`!=0). It is combinational from registers only and does not depend on `packet_valid`.
- **Accept:** occurs when `packet_valid && packet_ready` at an edge.
  - Packet is loaded into a 160-bit shift register and `credit_count` decrements.
  - Next state is SEND with `flit_idx`=0.
- **SEND:** `channel_out` = shift register [159:128]. Each edge shifts left 32 and increments `flit_idx`.
- **Exit SEND:** after the edge at which `flit_idx`==FLITS-1, state returns to IDLE and `channel_out` is 0.
- **Inter-packet gap:** IDLE always drives 0. This guarantees at least one zero cycle between packets, which the receiver requires to detect the next header.
- **Zero header:** if [159:128]==0 at accept, the packet is consumed but not sent.
  - `header_error` pulses; no credit is spent; state stays IDLE.
  - Reason: a zero header is indistinguishable from idle.
- **Credits:**
  - `credit_in` high with no accept: +1.
  - Accept with no `credit_in`: -1.
  - Both in the same cycle: unchanged.
  - `credit_in` while counter==CREDITS and no accept: saturate and pulse `credit_overflow`.
- **Body flits:** mid-packet flits may be zero; only the header must be non-zero.

## Timing
- **Reset values:**
  - `channel_out`=0, state IDLE, `flit_idx`=0.
  - `credit_count`=CREDITS, `header_error`=0, `credit_overflow`=0, serial=0.
- **Latency:** accept at edge N puts the header on `channel_out` during cycle N+1. Flits 1..4 appear in cycles N+2..N+5. Cycle N+6 is zero.
- **Throughput:** `packet_ready` is high again in cycle N+6. Minimum packet period is 6 cycles.
- **Reset mid-packet:** `channel_out` is 0 the cycle after reset is sampled. The partial packet is abandoned; credits reload to CREDITS and pending credit returns are discarded.
- **Credit timing:** `credit_in` affects `packet_ready` one cycle after it is sampled.

## Configuration
- `PACKET_SERIAL_STAMP_EN` defined:
  - An 18-bit serial counter overwrites header bits [145:128] at accept.
  - The counter increments per packet actually sent and wraps 2^18-1 → 0.
  - The zero-header check applies to the stamped header.
- Not defined: `packet_in` is transmitted unmodified and no serial counter exists.

## Structure
- **`packet_type.vh`:** `PACKET_TYPE` (160-bit), `CHANNEL_WIDTH`, `FLITS`, serial field bounds 145:128.
- **`system.vh`:** port codes `X_NEG`/`X_POS`/`Y_NEG`/`Y_POS`/`PE`. FSM state encodings stay local.
- **Sub-module `credit_counter`:** parameter CREDITS; inputs `consume`, `give`; outputs `count`, `nonzero`, `overflow`. It is reused by router output ports.

## Test plan
- **Reset and single send:** reset, then `packet_valid` with packet 0x00000001_…_00000005 at edge N. Expect `channel_out` = 1,2,3,4,5 in cycles N+1..N+5, then 0. Expect `credit_count` 4→3.
- **Credit exhaustion:** hold `packet_valid` with `credit_in`=0. Expect 4 packets at 6-cycle period, then `packet_ready`=0 and `channel_out`=0 indefinitely. A single `credit_in` pulse releases exactly one more packet.
- **Simultaneous accept and credit:** accept with `credit_in`=1 at count 2. Expect count stays 2. `credit_in` at count 4 with no accept pulses `credit_overflow`; count stays 4.
- **Zero header:** header 0x00000000. Expect `header_error` pulse, no flits, count unchanged, `packet_ready` still high.
- **Reset mid-packet:** assert reset during flit 2. Expect `channel_out`=0 next cycle and count=4. A fresh packet is sent correctly afterwards.
- **With `PACKET_SERIAL_STAMP_EN`:** send 3 packets. Expect header bits [145:128] = 0,1,2 as logged by the `sink` model. Preload serial 2^18-1 via force; expect next stamp 0.
